// File: rtl/serv_axi_pkg.sv
// Shared response codes and FSM state encoding for the AXI4-Lite memory responder.
package serv_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        W_ACC,
        W_RESP,
        R_ACC,
        R_DATA
    } axi_state_e;

endpackage

// File: rtl/serv_bram_be.sv
// DEPTH x 32 single-clock RAM with per-byte write enables and a registered read port.
module serv_bram_be #(
    parameter int    DEPTH   = 512,
    parameter int    RAW     = 9,
    parameter string MEMFILE = ""
) (
    input  logic           i_clk,
    input  logic [3:0]     i_we,
    input  logic [RAW-1:0] i_waddr,
    input  logic [31:0]    i_wdata,
    input  logic           i_re,
    input  logic [RAW-1:0] i_raddr,
    output logic [31:0]    o_rdata
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Byte-lane writes and synchronous read; rdata_q holds until the next read enable.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we[b]) mem_q[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
        if (i_re) rdata_q <= mem_q[i_raddr];
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/axi_lite_mem_responder.sv
// AXI4-Lite responder: single outstanding transaction, alternating arbitration on ties,
// SLVERR for word indices beyond DEPTH.
module axi_lite_mem_responder
    import serv_axi_pkg::*;
#(
    parameter int    AW      = 12,
    parameter int    DEPTH   = 512,
    parameter string MEMFILE = ""
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [AW-1:0] i_awaddr,
    input  logic          i_awvalid,
    output logic          o_awready,
    input  logic [31:0]   i_wdata,
    input  logic [3:0]    i_wstrb,
    input  logic          i_wvalid,
    output logic          o_wready,
    output logic [1:0]    o_bresp,
    output logic          o_bvalid,
    input  logic          i_bready,
    input  logic [AW-1:0] i_araddr,
    input  logic          i_arvalid,
    output logic          o_arready,
    output logic [31:0]   o_rdata,
    output logic [1:0]    o_rresp,
    output logic          o_rlast,
    output logic          o_rvalid,
    input  logic          i_rready
);

    localparam int IW  = AW - 2;
    localparam int RAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    function automatic logic in_range(input logic [IW-1:0] idx);
        return 32'(idx) < 32'(DEPTH);
    endfunction

    axi_state_e     state_q, state_d;
    logic           last_wr_q, last_wr_d;   // 0 = last served was a read
    logic           aw_got_q, aw_got_d;
    logic           w_got_q, w_got_d;
    logic [IW-1:0]  widx_q, widx_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [3:0]     wstrb_q, wstrb_d;
    logic [1:0]     bresp_q, bresp_d;
    logic [1:0]     rresp_q, rresp_d;

    logic [3:0]     ram_we;
    logic           ram_re;
    logic [31:0]    ram_rdata;
    logic [IW-1:0]  widx_cur, ridx;
    logic [31:0]    wdata_cur;
    logic [3:0]     wstrb_cur;
    logic           aw_hs, w_hs;
    logic           unused_addr_bits;

    // Address low bits select a byte within the word and are deliberately ignored.
    assign unused_addr_bits = ^{i_awaddr[1:0], i_araddr[1:0]};

    // Values as they will be after this cycle's handshakes, so a write can commit
    // in the same cycle its last half arrives.
    assign aw_hs     = (state_q == W_ACC) && !aw_got_q && i_awvalid;
    assign w_hs      = (state_q == W_ACC) && !w_got_q && i_wvalid;
    assign widx_cur  = aw_got_q ? widx_q  : i_awaddr[AW-1:2];
    assign wdata_cur = w_got_q  ? wdata_q : i_wdata;
    assign wstrb_cur = w_got_q  ? wstrb_q : i_wstrb;
    assign ridx      = i_araddr[AW-1:2];

    // Next-state, channel handshakes, RAM control and response capture.
    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        widx_d    = widx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        rresp_d   = rresp_q;
        o_awready = 1'b0;
        o_wready  = 1'b0;
        o_bvalid  = 1'b0;
        o_arready = 1'b0;
        o_rvalid  = 1'b0;
        o_rlast   = 1'b0;
        ram_we    = 4'b0;
        ram_re    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if ((i_awvalid || i_wvalid) && (!i_arvalid || !last_wr_q)) begin
                    state_d   = W_ACC;
                    last_wr_d = 1'b1;
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                end else if (i_arvalid) begin
                    state_d   = R_ACC;
                    last_wr_d = 1'b0;
                end
            end
            W_ACC: begin
                o_awready = !aw_got_q;
                o_wready  = !w_got_q;
                if (aw_hs) begin
                    aw_got_d = 1'b1;
                    widx_d   = i_awaddr[AW-1:2];
                end
                if (w_hs) begin
                    w_got_d = 1'b1;
                    wdata_d = i_wdata;
                    wstrb_d = i_wstrb;
                end
                if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
                    if (in_range(widx_cur)) begin
                        ram_we  = wstrb_cur;
                        bresp_d = RESP_OKAY;
                    end else begin
                        bresp_d = RESP_SLVERR;
                    end
                    state_d = W_RESP;
                end
            end
            W_RESP: begin
                o_bvalid = 1'b1;
                if (i_bready) state_d = IDLE;
            end
            R_ACC: begin
                o_arready = 1'b1;
                ram_re    = in_range(ridx);
                rresp_d   = in_range(ridx) ? RESP_OKAY : RESP_SLVERR;
                state_d   = R_DATA;
            end
            R_DATA: begin
                o_rvalid = 1'b1;
                o_rlast  = 1'b1;
                if (i_rready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and captured-transaction registers; reset aborts any transaction in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            last_wr_q <= 1'b0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            widx_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RESP_OKAY;
            rresp_q   <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            widx_q    <= widx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
        end
    end

    serv_bram_be #(
        .DEPTH   (DEPTH),
        .RAW     (RAW),
        .MEMFILE (MEMFILE)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (ram_we),
        .i_waddr (widx_cur[RAW-1:0]),
        .i_wdata (wdata_cur),
        .i_re    (ram_re),
        .i_raddr (ridx[RAW-1:0]),
        .o_rdata (ram_rdata)
    );

    assign o_bresp = bresp_q;
    assign o_rresp = rresp_q;
    // Data is forced to zero outside R_DATA and on an error response.
    assign o_rdata = (state_q == R_DATA && rresp_q == RESP_OKAY) ? ram_rdata : 32'h0;

endmodule
